// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam int unsigned MD_STALL_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  output logic       load_use
);

  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
               ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, branch flush,
// mult/div freeze FSM and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MD_STALL = MD_STALL_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The start cycle counts as the first freeze cycle, so the busy run is MD_STALL-1 long.
  localparam logic [7:0]       MD_CNT_INIT = 8'(MD_STALL - 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       load_use;

  hazard_detect u_hazard_detect (
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_uses_rt  (if_id_uses_rt),
    .load_use       (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      md_cnt_d     = '0;
    end else begin
      unique case (state_q)
        // MD_DONE shares RUN's decode; md_start there is the finishing mult/div.
        RUN, MD_DONE: begin
          state_d = RUN;
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (md_start && (state_q == RUN)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            md_cnt_d     = MD_CNT_INIT;
            state_d      = MD_BUSY;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          md_busy      = 1'b1;
          if (md_cnt_q == 8'd0) state_d = MD_DONE;
          else                  md_cnt_d = md_cnt_q - 8'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                  stall_cycles <= '0;
    else if (!pc_write && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default widths plus a CNT_W=4 instance).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_ex_mem_read = 1'b0;
  logic [4:0] id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic       if_id_uses_rt = 1'b0, branch_taken = 1'b0, md_start = 1'b0;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, md_busy;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_flush, s_md_busy;
  logic [3:0]  s_stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_STALL(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .md_start(md_start), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MD_STALL(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .md_start(md_start), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_write(s_id_ex_write),
    .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .md_busy(s_md_busy),
    .stall_cycles(s_stall_cycles)
  );

  // Output flag order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, md_busy
  localparam logic [6:0] O_RUN = 7'b1101000;
  localparam logic [6:0] O_LU  = 7'b0001100;
  localparam logic [6:0] O_BR  = 7'b1111100;
  localparam logic [6:0] O_FRZ = 7'b0000010;
  localparam logic [6:0] O_BSY = 7'b0000011;
  localparam logic [6:0] O_RST = 7'b0010110;

  typedef struct packed {
    logic [6:0]  flags;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } obs_t;

  typedef struct packed {
    logic [6:0] o;
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic       ur, bt, md, rst;
  } step_t;

  obs_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;

  function automatic step_t mk(input logic [6:0] o, input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic bt, input logic md, input logic rst);
    step_t s;
    s.o = o; s.mr = mr; s.ert = ert; s.rs = rs; s.rt = rt;
    s.ur = ur; s.bt = bt; s.md = md; s.rst = rst;
    return s;
  endfunction

  function automatic obs_t observe();
    obs_t g;
    g.flags = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, md_busy};
    g.cnt   = stall_cycles;
    g.cnt4  = s_stall_cycles;
    return g;
  endfunction

  // Drive one cycle, push its expectation, advance the counter model, sample at negedge.
  task automatic apply(input step_t s);
    obs_t e;
    @(posedge clk); #1;
    id_ex_mem_read = s.mr; id_ex_rt = s.ert; if_id_rs = s.rs; if_id_rt = s.rt;
    if_id_uses_rt = s.ur; branch_taken = s.bt; md_start = s.md; reset = s.rst;
    e.flags = s.o; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    exp_q.push_back(e);
    if (s.rst) begin
      m_cnt = '0; m_cnt4 = '0;
    end else if (!s.o[6]) begin
      if (m_cnt  != 16'hffff) m_cnt  = m_cnt + 16'd1;
      if (m_cnt4 != 4'hf)     m_cnt4 = m_cnt4 + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_RST, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(O_RST, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_LU,  1, 8, 8, 0, 0, 0, 0, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(O_RUN, 1, 0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(O_RUN, 1, 9, 3, 9, 0, 0, 0, 0));
    t.push_back(mk(O_LU,  1, 9, 3, 9, 1, 0, 0, 0));
    t.push_back(mk(O_RUN, 0, 9, 9, 9, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL load_use[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_BR,  1, 8, 8, 0, 0, 1, 0, 0));
    t.push_back(mk(O_BR,  0, 0, 0, 0, 0, 1, 0, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL branch[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_mult_div();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_FRZ, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 1, 8, 8, 0, 0, 1, 1, 0));
    t.push_back(mk(O_BSY, 1, 8, 8, 0, 0, 0, 1, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 1, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mult_div[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_FRZ, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BR,  0, 0, 0, 0, 0, 1, 1, 0));
    t.push_back(mk(O_LU,  1, 4, 4, 0, 0, 0, 0, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_freeze();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_FRZ, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_BSY, 0, 0, 0, 0, 0, 0, 1, 0));
    t.push_back(mk(O_RST, 0, 0, 0, 0, 0, 0, 1, 1));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_mid_freeze[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_saturation();
    step_t t[$];
    obs_t g, e;
    t.push_back(mk(O_RST, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int unsigned k = 0; k < 20; k++) t.push_back(mk(O_LU, 1, 5, 5, 0, 0, 0, 0, 0));
    t.push_back(mk(O_RUN, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      g = observe(); e = exp_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL saturation[%0d] got=%h expected=%h", i, g, e);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mult_div();
    test_back_to_back();
    test_reset_mid_freeze();
    test_saturation();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush (bubble) controls. It resolves three cases: load-use hazards (1-cycle stall), taken branches resolved in EX (flush of the two younger stages), and multi-cycle mult/div occupancy of EX (a fixed-length freeze run by a small FSM). It also keeps a saturating stall-cycle performance counter.

Parameters:
MD_STALL, 4, number of stall cycles a mult/div holds EX; legal range 2..255
CNT_W, 16, width of the stall_cycles performance counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
id_ex_mem_read  input  1  instruction in EX is a load (MemRead of the ID/EX stage)
id_ex_rt  input  5  destination rt of the instruction in EX
if_id_rs  input  5  rs field of the instruction in ID
if_id_rt  input  5  rt field of the instruction in ID
if_id_uses_rt  input  1  instruction in ID reads rt as a source (R-type, store, beq)
branch_taken  input  1  branch in EX resolved taken this cycle
md_start  input  1  instruction in EX is mult/div
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID register loads a NOP
id_ex_write  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX loads all-zero control signals (bubble)
ex_mem_flush  output  1  EX/MEM loads all-zero control signals
md_busy  output  1  FSM is in MD_BUSY
stall_cycles  output  CNT_W  count of cycles with pc_write==0, saturating

Behaviour:
- Decision outputs are combinational from the registered state and the current inputs, with zero latency, so the hazard is acted on in the same cycle it appears. Only state, md_cnt and stall_cycles are registered.
- Reset (sampled at rising clk):
  - Registered values: state=RUN, md_cnt=0, stall_cycles=0.
  - While reset is high: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, md_busy=0.
  - Reset in the middle of MD_BUSY aborts the stall; the block is in RUN on the next cycle.
- Default (no event): pc_write=1, if_id_write=1, id_ex_write=1, all flushes 0.
- load_use = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- FSM states:
  - RUN, in priority order:
    1. branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. Branch beats load_use.
    2. md_start: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1; md_cnt<=MD_STALL-2; next state MD_BUSY.
    3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1; stay in RUN. This is exactly a 1-cycle stall, because the load advances on the next edge.
  - MD_BUSY:
    - Same freeze outputs as RUN case 2; md_busy=1.
    - branch_taken, md_start and load_use are ignored.
    - If md_cnt==0, next state is MD_DONE; otherwise md_cnt decrements.
  - MD_DONE: default outputs; md_start is ignored (it is the same mult/div, still in EX for one more cycle); branch_taken and load_use are handled exactly as in RUN; next state RUN.
- Total freeze per mult/div is exactly MD_STALL cycles. The instruction leaves EX at the end of the MD_DONE cycle.
- Back-to-back mult/div: a second mult/div asserting md_start in the cycle after MD_DONE starts a new sequence.
- stall_cycles increments on every non-reset cycle with pc_write==0. It holds at 2^CNT_W-1 and never wraps.
- md_cnt width is 8 bits.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encoding as a 2-bit enum: RUN=0, MD_BUSY=1, MD_DONE=2; value 3 is illegal and recovers to RUN.
  - constant REG_ZERO=5'd0.
  - default widths for MD_STALL and CNT_W.
- Sub-module hazard_detect: purely combinational load_use comparator, reused later by the forwarding unit.
- The top level holds the FSM, md_cnt, output decode and the performance counter.

Test Plan:
- Reset: hold reset 2 cycles, then release with all inputs 0 -> during reset pc_write=0 and all flushes=1; first cycle after release pc_write=1, if_id_write=1, flushes=0, stall_cycles=0.
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 for one cycle -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1. Repeat with id_ex_rt=0 -> no stall.
- rt gating: id_ex_rt=9, if_id_rt=9, if_id_uses_rt=0 -> no stall; with if_id_uses_rt=1 -> stall.
- Branch beats load-use: branch_taken=1 together with a load_use match -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1; stall_cycles unchanged.
- Mult/div sequence: MD_STALL=4, md_start held high -> exactly 4 cycles of freeze (md_busy=1 in the last 3), then 1 MD_DONE cycle with pc_write=1 despite md_start=1, then RUN; stall_cycles=4.
- Reset mid-freeze: reset asserted in the 2nd MD_BUSY cycle -> next cycle state RUN, md_busy=0, stall_cycles=0.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cycles stops at 15.
